spike_encoder: RTL



---
 rtl/snn_pkg.sv | 36 +++
 rtl/spike_lfsr.sv | 25 ++
 rtl/spike_encoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared types and constants for the SNN input/readout blocks.
//   enc_mode_e  : per-frame encoding select (rate / delta)
//   enc_state_e : spike encoder frame state
//   enc_req_t   : sample latched at frame start
//   enc_dec_t   : one timestep spike decision
//   lfsr8_next  : one step of the 8-bit Galois LFSR
package snn_pkg;

    typedef enum logic {
        ENC_RATE  = 1'b0,
        ENC_DELTA = 1'b1
    } enc_mode_e;

    typedef enum logic {
        ENC_IDLE   = 1'b0,
        ENC_ENCODE = 1'b1
    } enc_state_e;

    // Right-shift Galois form of x^8+x^6+x^5+x^4+1 (maximal length, period 255).
    localparam logic [7:0] LFSR8_TAPS = 8'hB8;

    typedef struct packed {
        logic [7:0] data;
        enc_mode_e  mode;
    } enc_req_t;

    typedef struct packed {
        logic spike;
        logic up;
    } enc_dec_t;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? LFSR8_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/spike_lfsr.sv
// spike_lfsr: 8-bit Galois LFSR used as the rate-coding random source.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset, loads SEED
//   advance_i : step the register once on this edge
//   value_o   : current LFSR value, never 0 for a nonzero SEED
module spike_lfsr
    import snn_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hB8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       advance_i,
    output logic [7:0] value_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            value_o <= SEED;
        end else if (advance_i) begin
            value_o <= lfsr8_next(value_o);
        end
    end

endmodule

// File: rtl/spike_encoder.sv
// spike_encoder: turns one 8-bit sample into a NUM_STEPS-long spike train.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   data_i, mode_i  : sample and encoding (0 rate, 1 delta), taken with valid_i
//   valid_i/ready_o : sample handshake; ready_o is low for the whole frame
//   spike_o         : spike for the current timestep
//   polarity_o      : 1 up, 0 down (always 1 in rate mode)
//   spike_valid_o   : spike_o/polarity_o/step_o are meaningful
//   step_o          : timestep index 0..NUM_STEPS-1
//   frame_done_o    : high on the last timestep of a frame
//   spike_count_o   : spikes so far in this frame; holds after the frame
module spike_encoder
    import snn_pkg::*;
#(
    parameter int         WIDTH_P   = 8,
    parameter int         NUM_STEPS = 16,
    parameter logic [7:0] SEED      = 8'hB8,
    parameter logic [7:0] DELTA_TH  = 8'd20
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [WIDTH_P-1:0] data_i,
    input  logic               mode_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               spike_o,
    output logic               polarity_o,
    output logic               spike_valid_o,
    output logic [7:0]         step_o,
    output logic               frame_done_o,
    output logic [7:0]         spike_count_o
);

    localparam logic [7:0] LAST_STEP = 8'(NUM_STEPS - 1);

    enc_state_e state;
    enc_req_t   req_q;
    enc_req_t   cur;
    enc_dec_t   dec;
    logic [7:0] ref_q;
    logic [7:0] ref_nxt;
    logic [7:0] lfsr_val;
    logic       accept;
    logic       last;
    logic       do_step;
    logic       lfsr_adv;

    spike_lfsr #(.SEED(SEED)) u_lfsr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .advance_i (lfsr_adv),
        .value_o   (lfsr_val)
    );

    // Step 0 is decided on the accepting edge straight from data_i/mode_i so
    // that the first registered timestep appears the very next cycle; later
    // steps use the latched request.
    always_comb begin
        accept  = (state == ENC_IDLE) && valid_i;
        last    = (state == ENC_ENCODE) && (step_o == LAST_STEP);
        do_step = accept || ((state == ENC_ENCODE) && !last);

        cur = req_q;
        if (accept) begin
            cur.data = data_i;
            cur.mode = enc_mode_e'(mode_i);
        end

        dec     = '0;
        ref_nxt = ref_q;
        if (cur.mode == ENC_RATE) begin
            dec.spike = (cur.data > lfsr_val);
            dec.up    = 1'b1;
        end else if ((cur.data >= ref_q) && ((cur.data - ref_q) >= DELTA_TH)) begin
            dec.spike = 1'b1;
            dec.up    = 1'b1;
            ref_nxt   = ref_q + DELTA_TH;
        end else if ((ref_q > cur.data) && ((ref_q - cur.data) >= DELTA_TH)) begin
            dec.spike = 1'b1;
            dec.up    = 1'b0;
            ref_nxt   = ref_q - DELTA_TH;
        end

        lfsr_adv = do_step && (cur.mode == ENC_RATE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state         <= ENC_IDLE;
            req_q         <= '0;
            ref_q         <= '0;
            ready_o       <= 1'b1;
            spike_o       <= 1'b0;
            polarity_o    <= 1'b0;
            spike_valid_o <= 1'b0;
            step_o        <= '0;
            frame_done_o  <= 1'b0;
            spike_count_o <= '0;
        end else begin
            if (do_step) begin
                spike_o       <= dec.spike;
                polarity_o    <= dec.spike ? dec.up : (cur.mode == ENC_RATE);
                spike_valid_o <= 1'b1;
                ref_q         <= ref_nxt;
                if (accept) begin
                    state         <= ENC_ENCODE;
                    req_q         <= cur;
                    ready_o       <= 1'b0;
                    step_o        <= '0;
                    frame_done_o  <= 1'b0;
                    spike_count_o <= {7'd0, dec.spike};
                end else begin
                    step_o        <= step_o + 8'd1;
                    frame_done_o  <= ((step_o + 8'd1) == LAST_STEP);
                    spike_count_o <= spike_count_o + {7'd0, dec.spike};
                end
            end else if (last) begin
                // Final timestep was on screen this cycle; close the frame.
                state         <= ENC_IDLE;
                ready_o       <= 1'b1;
                spike_o       <= 1'b0;
                polarity_o    <= 1'b0;
                spike_valid_o <= 1'b0;
                step_o        <= '0;
                frame_done_o  <= 1'b0;
            end
        end
    end

endmodule
